// File: rtl/maxpool_pkg.sv
// Shared definitions for the 2x2 max-pooling block: default sample width and
// the window index type and constants.
package maxpool_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  typedef logic [1:0] idx_t;

  localparam idx_t IDX_IN1 = 2'd0;
  localparam idx_t IDX_IN2 = 2'd1;
  localparam idx_t IDX_IN3 = 2'd2;
  localparam idx_t IDX_IN4 = 2'd3;

endpackage

// File: rtl/maxpool_max2.sv
// Two-operand max comparator. Operand a wins ties, so callers must pass the
// lower-index operand as a.
module max2
  import maxpool_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter bit          SIGNED = 1'b0
) (
  input  logic [DATA_W-1:0] i_a,
  input  idx_t              i_a_idx,
  input  logic [DATA_W-1:0] i_b,
  input  idx_t              i_b_idx,
  output logic [DATA_W-1:0] o_max,
  output idx_t              o_idx
);

  logic w_b_gt;

  always_comb begin
    w_b_gt = 1'b0;
    if (SIGNED) begin
      w_b_gt = $signed(i_b) > $signed(i_a);
    end else begin
      w_b_gt = i_b > i_a;
    end
  end

  // Strictly-greater test keeps operand a on equality.
  assign o_max = w_b_gt ? i_b : i_a;
  assign o_idx = w_b_gt ? i_b_idx : i_a_idx;

endmodule

// File: rtl/maxpool.sv
// Two-stage valid/ready pipeline returning the maximum of a 2x2 window and the
// index of the winning element.
module maxpool
  import maxpool_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter bit          SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [DATA_W-1:0] in4,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] op,
  output idx_t              op_idx
);

  logic [DATA_W-1:0] w_p0_max, w_p1_max, w_fin_max;
  idx_t              w_p0_idx, w_p1_idx, w_fin_idx;
  logic              w_s1_adv, w_s2_adv;

  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_max0, r_s1_max1;
  idx_t              r_s1_idx0, r_s1_idx1;
  logic              r_s2_valid;
  logic [DATA_W-1:0] r_s2_max;
  idx_t              r_s2_idx;

  max2 #(.DATA_W(DATA_W), .SIGNED(SIGNED)) u_max_row0 (
    .i_a    (in1),
    .i_a_idx(IDX_IN1),
    .i_b    (in2),
    .i_b_idx(IDX_IN2),
    .o_max  (w_p0_max),
    .o_idx  (w_p0_idx)
  );

  max2 #(.DATA_W(DATA_W), .SIGNED(SIGNED)) u_max_row1 (
    .i_a    (in3),
    .i_a_idx(IDX_IN3),
    .i_b    (in4),
    .i_b_idx(IDX_IN4),
    .o_max  (w_p1_max),
    .o_idx  (w_p1_idx)
  );

  // Row 0 result sits on operand a so it wins ties against row 1.
  max2 #(.DATA_W(DATA_W), .SIGNED(SIGNED)) u_max_final (
    .i_a    (r_s1_max0),
    .i_a_idx(r_s1_idx0),
    .i_b    (r_s1_max1),
    .i_b_idx(r_s1_idx1),
    .o_max  (w_fin_max),
    .o_idx  (w_fin_idx)
  );

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_max0  <= '0;
      r_s1_max1  <= '0;
      r_s1_idx0  <= IDX_IN1;
      r_s1_idx1  <= IDX_IN1;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_max0 <= w_p0_max;
        r_s1_max1 <= w_p1_max;
        r_s1_idx0 <= w_p0_idx;
        r_s1_idx1 <= w_p1_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_max   <= '0;
      r_s2_idx   <= IDX_IN1;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_max <= w_fin_max;
        r_s2_idx <= w_fin_idx;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign op        = r_s2_max;
  assign op_idx    = r_s2_idx;

endmodule

// File: tb/tb_maxpool.sv
// Directed bench for maxpool: an unsigned and a signed instance share stimulus.
module tb_maxpool;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in1, in2, in3, in4;
  logic       out_ready;
  logic       in_ready_u, in_ready_s;
  logic       out_valid_u, out_valid_s;
  logic [7:0] op_u, op_s;
  logic [1:0] op_idx_u, op_idx_s;

  int n_chk = 0;
  int n_err = 0;
  int got_q[$];
  bit acc;
  int k;

  maxpool #(.DATA_W(8), .SIGNED(1'b0)) dut_u (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready_u),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .in4      (in4),
    .out_ready(out_ready),
    .out_valid(out_valid_u),
    .op       (op_u),
    .op_idx   (op_idx_u)
  );

  maxpool #(.DATA_W(8), .SIGNED(1'b1)) dut_s (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready_s),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .in4      (in4),
    .out_ready(out_ready),
    .out_valid(out_valid_s),
    .op       (op_s),
    .op_idx   (op_idx_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, b, c, d);
    in1 = a;
    in2 = b;
    in3 = c;
    in4 = d;
  endtask

  // Present one window with out_ready high; leaves the bench two edges later.
  task automatic run_window(input logic [7:0] a, b, c, d);
    drive(a, b, c, d);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    drive(8'hEE, 8'hEE, 8'hEE, 8'hEE);
    chk("lat_cycle1_valid", {7'd0, out_valid_u}, 8'd0);
    step();
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(8'h00, 8'h00, 8'h00, 8'h00);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", {7'd0, in_ready_u}, 8'd1);
    chk("rst_out_valid", {7'd0, out_valid_u}, 8'd0);
    chk("rst_op", op_u, 8'h00);
    chk("rst_op_idx", {6'd0, op_idx_u}, 8'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", {7'd0, in_ready_u}, 8'd1);

    // Basic unsigned window, one-cycle output pulse.
    run_window(8'h10, 8'h80, 8'h7F, 8'h01);
    chk("basic_valid", {7'd0, out_valid_u}, 8'd1);
    chk("basic_op", op_u, 8'h80);
    chk("basic_idx", {6'd0, op_idx_u}, 8'd1);
    step();
    chk("basic_pulse_end", {7'd0, out_valid_u}, 8'd0);

    // Signed vs unsigned ordering on the same window.
    run_window(8'h80, 8'hFF, 8'h7F, 8'h00);
    chk("uns_op", op_u, 8'hFF);
    chk("uns_idx", {6'd0, op_idx_u}, 8'd1);
    chk("sgn_valid", {7'd0, out_valid_s}, 8'd1);
    chk("sgn_op", op_s, 8'h7F);
    chk("sgn_idx", {6'd0, op_idx_s}, 8'd2);
    step();

    // Tie handling.
    run_window(8'h55, 8'h55, 8'h55, 8'h55);
    chk("tie_all_op", op_u, 8'h55);
    chk("tie_all_idx", {6'd0, op_idx_u}, 8'd0);
    step();
    run_window(8'h10, 8'h10, 8'h90, 8'h90);
    chk("tie_row1_op", op_u, 8'h90);
    chk("tie_row1_idx", {6'd0, op_idx_u}, 8'd2);
    chk("tie_row1_sgn_idx", {6'd0, op_idx_s}, 8'd0);
    step();

    // Backpressure: fill both stages, then hold.
    out_ready = 1'b0;
    k = 1;
    drive(8'h00, 8'(k), 8'h00, 8'h00);
    in_valid = 1'b1;
    step();
    k = 2;
    drive(8'h00, 8'(k), 8'h00, 8'h00);
    step();
    k = 3;
    drive(8'h00, 8'(k), 8'h00, 8'h00);
    chk("bp_in_ready_low", {7'd0, in_ready_u}, 8'd0);
    chk("bp_valid", {7'd0, out_valid_u}, 8'd1);
    chk("bp_op", op_u, 8'h01);
    step();
    step();
    chk("bp_hold_op", op_u, 8'h01);
    chk("bp_hold_idx", {6'd0, op_idx_u}, 8'd1);
    chk("bp_hold_valid", {7'd0, out_valid_u}, 8'd1);
    chk("bp_hold_ready", {7'd0, in_ready_u}, 8'd0);
    out_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 20 && got_q.size() < 4; cyc++) begin
      if (out_valid_u) got_q.push_back(int'(op_u));
      acc = in_valid && in_ready_u;
      step();
      if (acc) begin
        k++;
        if (k <= 4) drive(8'h00, 8'(k), 8'h00, 8'h00);
        else in_valid = 1'b0;
      end
    end
    chk("bp_count", 8'(got_q.size()), 8'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) chk("bp_order", 8'(got_q[i]), 8'(i + 1));
    end
    in_valid = 1'b0;
    step();
    chk("bp_drained", {7'd0, out_valid_u}, 8'd0);

    // Reset with both stages full.
    out_ready = 1'b0;
    drive(8'h00, 8'hAA, 8'h00, 8'h00);
    in_valid = 1'b1;
    step();
    step();
    chk("mid_full_valid", {7'd0, out_valid_u}, 8'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {7'd0, out_valid_u}, 8'd0);
    chk("mid_rst_op", op_u, 8'h00);
    chk("mid_rst_idx", {6'd0, op_idx_u}, 8'd0);
    chk("mid_rst_ready", {7'd0, in_ready_u}, 8'd1);
    in_valid = 1'b0;
    step();
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    drive(8'h01, 8'h02, 8'h22, 8'h03);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("after_rst_lat1", {7'd0, out_valid_u}, 8'd0);
    step();
    chk("after_rst_valid", {7'd0, out_valid_u}, 8'd1);
    chk("after_rst_op", op_u, 8'h22);
    chk("after_rst_idx", {6'd0, op_idx_u}, 8'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
